// File: rtl/dds_pkg.sv
// dds_pkg: quadrant encodings and tuning-word helpers shared by
// the DDS phase controller and its quadrant mapper.
package dds_pkg;

  typedef enum logic [1:0] {
    QUAD_FIRST  = 2'b00,
    QUAD_SECOND = 2'b01,
    QUAD_THIRD  = 2'b10,
    QUAD_FOURTH = 2'b11
  } quad_e;

  // One quarter-table address per clock at the given widths.
  function automatic int unsigned default_ftw(
    input int unsigned acc_w,
    input int unsigned addr_w
  );
    return 32'd1 << (acc_w - addr_w - 2);
  endfunction

endpackage

// File: rtl/dds_quadrant_map.sv
// dds_quadrant_map: phase word to mirrored quarter-table address,
// sign and descending-quarter flag. Purely combinational.
module dds_quadrant_map
  import dds_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic [ACC_W-1:0]  p_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              sign_o,
  output logic              pose_o
);

  localparam int LOW_W = ACC_W - ADDR_W - 2;

  quad_e             q;
  logic [ADDR_W-1:0] idx;

  assign q   = quad_e'(p_i[ACC_W-1 -: 2]);
  assign idx = p_i[ACC_W-3 -: ADDR_W];

  always_comb begin
    addr_o = idx;
    sign_o = 1'b0;
    pose_o = 1'b0;
    unique case (q)
      QUAD_FIRST: begin
        addr_o = idx;
      end
      QUAD_SECOND: begin
        addr_o = ~idx;
        pose_o = 1'b1;
      end
      QUAD_THIRD: begin
        addr_o = idx;
        sign_o = 1'b1;
      end
      QUAD_FOURTH: begin
        addr_o = ~idx;
        sign_o = 1'b1;
        pose_o = 1'b1;
      end
    endcase
  end

  // Fractional phase bits only matter for accumulation, not lookup.
  generate
    if (LOW_W > 0) begin : g_low
      logic unused_low;
      assign unused_low = ^p_i[LOW_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/dds_phase_ctrl.sv
// dds_phase_ctrl: FTW phase accumulator with wrap-aligned FTW update.
// Define DDS_PHASE_OFFSET_EN to add the phase_off input and adder.
module dds_phase_ctrl
  import dds_pkg::*;
#(
  parameter int          ACC_W     = 16,
  parameter int          ADDR_W    = 6,
  parameter int unsigned FTW_RESET = default_ftw(ACC_W, ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              ftw_load,
  input  logic [ACC_W-1:0]  ftw_in,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0]  phase_off,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              sign_bit,
  output logic              phase_pose,
  output logic              valid,
  output logic              wrap
);

  localparam logic [ACC_W-1:0] FTW_INIT = ACC_W'(FTW_RESET);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0]  ftw_pend_q, ftw_pend_d;
  logic              pend_q, pend_d;
  logic              carry_q, carry_d;
  logic [ADDR_W-1:0] addr_q;
  logic              sign_q;
  logic              pose_q;
  logic              valid_q;
  logic              wrap_q;

  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  p;
  logic              apply;
  logic [ADDR_W-1:0] map_addr;
  logic              map_sign;
  logic              map_pose;

  assign sum     = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign carry_d = en & ~sync_clr & sum[ACC_W];

  // Swap step size only at a period boundary or while idle so the
  // output phase never jumps; a clear is not a boundary.
  assign apply = pend_q & (carry_d | ~en);

  always_comb begin
    acc_d = acc_q;
    if (sync_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_comb begin
    ftw_act_d  = apply ? ftw_pend_q : ftw_act_q;
    ftw_pend_d = ftw_load ? ftw_in : ftw_pend_q;
    pend_d     = ftw_load | (pend_q & ~apply);
  end

`ifdef DDS_PHASE_OFFSET_EN
  assign p = acc_q + phase_off;
`else
  assign p = acc_q;
`endif

  dds_quadrant_map #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_map (
    .p_i    (p),
    .addr_o (map_addr),
    .sign_o (map_sign),
    .pose_o (map_pose)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      ftw_act_q  <= FTW_INIT;
      ftw_pend_q <= '0;
      pend_q     <= 1'b0;
      carry_q    <= 1'b0;
      addr_q     <= '0;
      sign_q     <= 1'b0;
      pose_q     <= 1'b0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ftw_act_q  <= ftw_act_d;
      ftw_pend_q <= ftw_pend_d;
      pend_q     <= pend_d;
      carry_q    <= carry_d;
      addr_q     <= map_addr;
      sign_q     <= map_sign;
      pose_q     <= map_pose;
      valid_q    <= en;
      wrap_q     <= carry_q;
    end
  end

  assign addr       = addr_q;
  assign sign_bit   = sign_q;
  assign phase_pose = pose_q;
  assign valid      = valid_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// tb_dds_phase_ctrl: directed vector bench for dds_phase_ctrl
// (ACC_W=16, ADDR_W=6); edge-indexed logs checked against tables.
module tb_dds_phase_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        sync_clr;
  logic        ftw_load;
  logic [15:0] ftw_in;
`ifdef DDS_PHASE_OFFSET_EN
  logic [15:0] phase_off;
`endif
  logic [5:0]  addr;
  logic        sign_bit;
  logic        phase_pose;
  logic        valid;
  logic        wrap;

  always #5 clk = ~clk;

  dds_phase_ctrl #(
    .ACC_W  (16),
    .ADDR_W (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sync_clr   (sync_clr),
    .ftw_load   (ftw_load),
    .ftw_in     (ftw_in),
`ifdef DDS_PHASE_OFFSET_EN
    .phase_off  (phase_off),
`endif
    .addr       (addr),
    .sign_bit   (sign_bit),
    .phase_pose (phase_pose),
    .valid      (valid),
    .wrap       (wrap)
  );

  typedef struct {
    int         scen;
    int         edg;
    logic [5:0] addr;
    logic       sgn;
    logic       pose;
    logic       vld;
    logic       wrp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_n = 0;

  logic [5:0] a_log [600];
  logic       s_log [600];
  logic       p_log [600];
  logic       v_log [600];
  logic       w_log [600];

  function automatic void add(int s, int e, int a, int sg, int po,
                              int v, int w);
    vec_t t;
    t.scen = s;
    t.edg  = e;
    t.addr = 6'(a);
    t.sgn  = sg[0];
    t.pose = po[0];
    t.vld  = v[0];
    t.wrp  = w[0];
    tbl.push_back(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (edge_n < 600) begin
      a_log[edge_n] = addr;
      s_log[edge_n] = sign_bit;
      p_log[edge_n] = phase_pose;
      v_log[edge_n] = valid;
      w_log[edge_n] = wrap;
    end
  endtask

  task automatic run_to(int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    en       = 1'b0;
    sync_clr = 1'b0;
    ftw_load = 1'b0;
    ftw_in   = '0;
    reset    = 1'b1;
    #1;
    reset    = 1'b0;
    edge_n   = 0;
  endtask

  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, got, got, exp, exp);
    end
  endtask

  task automatic check_scen(int s);
    foreach (tbl[i]) begin
      if (tbl[i].scen == s) begin
        int e;
        logic [9:0] got, exp;
        e   = tbl[i].edg;
        got = {a_log[e], s_log[e], p_log[e], v_log[e], w_log[e]};
        exp = {tbl[i].addr, tbl[i].sgn, tbl[i].pose,
               tbl[i].vld, tbl[i].wrp};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL s%0d_e%0d: got addr=%0d sign=%0d pose=%0d valid=%0d wrap=%0d expected addr=%0d sign=%0d pose=%0d valid=%0d wrap=%0d",
                   s, e, got[9:4], got[3], got[2], got[1], got[0],
                   exp[9:4], exp[3], exp[2], exp[1], exp[0]);
        end
      end
    end
  endtask

  function automatic int wraps(int lo, int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(w_log[i]);
    return c;
  endfunction

  initial begin
    // scen 1: default step 256 after reset release
    add(1,   1,  0, 0, 0, 1, 0);
    add(1,   2,  1, 0, 0, 1, 0);
    add(1,  64, 63, 0, 0, 1, 0);
    add(1,  65, 63, 0, 1, 1, 0);
    add(1,  66, 62, 0, 1, 1, 0);
    add(1, 128,  0, 0, 1, 1, 0);
    add(1, 129,  0, 1, 0, 1, 0);
    add(1, 130,  1, 1, 0, 1, 0);
    add(1, 192, 63, 1, 0, 1, 0);
    add(1, 193, 63, 1, 1, 1, 0);
    add(1, 256,  0, 1, 1, 1, 0);
    add(1, 257,  0, 0, 0, 1, 1);
    add(1, 258,  1, 0, 0, 1, 0);
    add(1, 513,  0, 0, 0, 1, 1);
    // scen 2: load 512 at acc=0x4000, applied at the wrap
    add(2,  64, 63, 0, 0, 1, 0);
    add(2,  65, 63, 0, 1, 1, 0);
    add(2,  66, 62, 0, 1, 1, 0);
    add(2, 255,  1, 1, 1, 1, 0);
    add(2, 256,  0, 1, 1, 1, 0);
    add(2, 257,  0, 0, 0, 1, 1);
    add(2, 258,  2, 0, 0, 1, 0);
    add(2, 259,  4, 0, 0, 1, 0);
    add(2, 384,  1, 1, 1, 1, 0);
    add(2, 385,  0, 0, 0, 1, 1);
    add(2, 386,  2, 0, 0, 1, 0);
    // scen 3: idle load of 1024, immediate apply
    add(3,   1,  0, 0, 0, 0, 0);
    add(3,   2,  0, 0, 0, 0, 0);
    add(3,   3,  0, 0, 0, 1, 0);
    add(3,   4,  4, 0, 0, 1, 0);
    add(3,   5,  8, 0, 0, 1, 0);
    add(3,  18, 60, 0, 0, 1, 0);
    add(3,  19, 63, 0, 1, 1, 0);
    add(3,  66,  3, 1, 1, 1, 0);
    add(3,  67,  0, 0, 0, 1, 1);
    add(3,  68,  4, 0, 0, 1, 0);
    // scen 4: sync_clr at acc=0x9300 with a load on the same edge
    add(4, 147, 18, 1, 0, 1, 0);
    add(4, 148, 19, 1, 0, 1, 0);
    add(4, 149,  0, 0, 0, 1, 0);
    add(4, 150,  1, 0, 0, 1, 0);
    add(4, 151,  2, 0, 0, 1, 0);
    // scen 5: phase offset 0x4000 then back to 0
    add(5,   1, 63, 0, 1, 1, 0);
    add(5,   2, 62, 0, 1, 1, 0);
    add(5,   3,  2, 0, 0, 1, 0);
    // scen 6: after mid-period reset with pending FTW
    add(6,   1,  0, 0, 0, 1, 0);
    add(6,   2,  1, 0, 0, 1, 0);
    add(6,   3,  2, 0, 0, 1, 0);
    add(6, 257,  0, 0, 0, 1, 1);
    add(6, 258,  1, 0, 0, 1, 0);

    en       = 1'b0;
    sync_clr = 1'b0;
    ftw_load = 1'b0;
    ftw_in   = '0;
`ifdef DDS_PHASE_OFFSET_EN
    phase_off = '0;
`endif
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("reset_state", int'({addr, sign_bit, phase_pose, valid, wrap}), 0);
    #1;
    reset = 1'b0;

    en = 1'b1;
    run_to(513);
    check_scen(1);
    chk("s1_wrap_count", wraps(1, 513), 2);

    do_reset();
    en = 1'b1;
    run_to(64);
    ftw_load = 1'b1;
    ftw_in   = 16'd512;
    step();
    ftw_load = 1'b0;
    run_to(386);
    check_scen(2);
    chk("s2_wraps_old_step", wraps(1, 256), 0);
    chk("s2_wraps_new_period", wraps(258, 384), 0);

    do_reset();
    ftw_load = 1'b1;
    ftw_in   = 16'd1024;
    step();
    ftw_load = 1'b0;
    step();
    en = 1'b1;
    run_to(68);
    check_scen(3);

    do_reset();
    en = 1'b1;
    run_to(147);
    sync_clr = 1'b1;
    ftw_load = 1'b1;
    ftw_in   = 16'd512;
    step();
    sync_clr = 1'b0;
    ftw_load = 1'b0;
    run_to(151);
    check_scen(4);

`ifdef DDS_PHASE_OFFSET_EN
    do_reset();
    phase_off = 16'h4000;
    en = 1'b1;
    run_to(2);
    phase_off = '0;
    run_to(3);
    check_scen(5);
`endif

    do_reset();
    en = 1'b1;
    run_to(196);
    ftw_load = 1'b1;
    ftw_in   = 16'd4096;
    step();
    ftw_load = 1'b0;
    chk("s6_pre_reset", int'({addr, sign_bit, phase_pose, valid, wrap}),
        int'({6'd59, 1'b1, 1'b1, 1'b1, 1'b0}));
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_reset", int'({addr, sign_bit, phase_pose, valid, wrap}), 0);
    #1;
    reset  = 1'b0;
    edge_n = 0;
    run_to(258);
    check_scen(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
